// File: rtl/snn_param_loader.sv
// snn_param_loader: serial (SPI mode 0) front-end that loads the SNN parameter
// memory. Host pins are synchronized to clk, words are assembled MSB-first and
// written through the memory write port at an auto-incrementing address.
// The first word of each frame is the start address; every later word is data.

module snn_param_loader #(
  parameter int M = 162,
  parameter int N = 8,
  localparam int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          cs_n,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_data,
  output logic          mem_write_enable,
  output logic          frame_done,
  output logic          overflow,
  output logic          busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  // The pointer is one bit wider than the address so that it can sit at M
  // (or above) when M is a power of two, instead of wrapping back to 0.
  localparam logic [AW:0] M_LIM = M[AW:0];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic          sclk_s1, sclk_s2, sclk_s3;
  logic          mosi_s1, mosi_s2;
  logic          cs_s1, cs_s2;
  logic          sclk_rise;
  logic [1:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [N-2:0]  shift_reg;
  logic [N-1:0]  word;
  logic [AW:0]   ptr;
  logic          wrote_any;

  // Bring the asynchronous host pins into the clk domain; cs_n idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
    end
  end

  // Rising sclk edge and the word as it would look with the current bit added.
  always_comb begin
    sclk_rise = sclk_s2 & ~sclk_s3;
    word      = {shift_reg, mosi_s2};
  end

  // Frame sequencing, word assembly and the memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      ptr              <= '0;
      wrote_any        <= 1'b0;
      mem_addr         <= '0;
      mem_data         <= '0;
      mem_write_enable <= 1'b0;
      frame_done       <= 1'b0;
      overflow         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      frame_done       <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_s2) begin
            state     <= ADDR;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            wrote_any <= 1'b0;
          end
        end
        default: begin
          if (cs_s2) begin
            // Frame ended: any partial word is simply dropped.
            state      <= IDLE;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            frame_done <= wrote_any;
          end else if (sclk_rise) begin
            shift_reg <= word[N-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                ptr   <= {1'b0, word[AW-1:0]};
                state <= DATA;
              end else if (ptr < M_LIM) begin
                mem_addr         <= ptr[AW-1:0];
                mem_data         <= word;
                mem_write_enable <= 1'b1;
                wrote_any        <= 1'b1;
                ptr              <= ptr + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_param_loader.sv
// tb_snn_param_loader: directed frames from a modelled SPI host, with every
// memory write strobe and frame_done pulse recorded and compared against
// hand-computed values.

module tb_snn_param_loader;

  localparam int M  = 162;
  localparam int N  = 8;
  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          sclk;
  logic          mosi;
  logic          cs_n;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data;
  logic          mem_write_enable;
  logic          frame_done;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wr_addr[$];
  logic [N-1:0]  wr_data[$];
  int            fd_count   = 0;
  int            long_we    = 0;
  logic          prev_we    = 1'b0;

  snn_param_loader #(.M(M), .N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .sclk             (sclk),
    .mosi             (mosi),
    .cs_n             (cs_n),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .frame_done       (frame_done),
    .overflow         (overflow),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe and frame_done pulse away from the active edge.
  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      if (prev_we) long_we++;
    end
    if (frame_done === 1'b1) fd_count++;
    prev_we = (mem_write_enable === 1'b1);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    fd_count = 0;
    long_we  = 0;
  endtask

  // Host: sclk half period is 4 clk cycles, cs_n setup/hold 4 clk cycles.
  task automatic start_frame();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7 - i];
      #40;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int gap_cycles);
    #40;
    cs_n = 1'b1;
    repeat (gap_cycles) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_mem_addr", 32'(mem_addr), 0);
    check_output("reset_mem_data", 32'(mem_data), 0);
    check_output("reset_we", 32'(mem_write_enable), 0);
    check_output("reset_frame_done", 32'(frame_done), 0);
    check_output("reset_overflow", 32'(overflow), 0);
    check_output("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Address 5, three data words.
    clear_log();
    start_frame();
    check_output("t1_busy_start", 32'(busy), 1);
    send_word(8'd5, 8);
    send_word(8'hA1, 8);
    send_word(8'hB2, 8);
    send_word(8'hC3, 8);
    end_frame(8);
    check_output("t1_write_count", wr_addr.size(), 3);
    check_output("t1_addr0", 32'(wr_addr[0]), 5);
    check_output("t1_data0", 32'(wr_data[0]), 32'hA1);
    check_output("t1_addr1", 32'(wr_addr[1]), 6);
    check_output("t1_data1", 32'(wr_data[1]), 32'hB2);
    check_output("t1_addr2", 32'(wr_addr[2]), 7);
    check_output("t1_data2", 32'(wr_data[2]), 32'hC3);
    check_output("t1_strobe_width", long_we, 0);
    check_output("t1_frame_done", fd_count, 1);
    check_output("t1_overflow", 32'(overflow), 0);
    check_output("t1_busy_end", 32'(busy), 0);
    check_output("t1_hold_addr", 32'(mem_addr), 7);
    check_output("t1_hold_data", 32'(mem_data), 32'hC3);

    // Address 160: two words fit, the rest overflow and the pointer saturates.
    clear_log();
    start_frame();
    send_word(8'd160, 8);
    send_word(8'h11, 8);
    send_word(8'h22, 8);
    check_output("t2_no_overflow_yet", 32'(overflow), 0);
    send_word(8'h33, 8);
    check_output("t2_overflow_word3", 32'(overflow), 1);
    send_word(8'h44, 8);
    end_frame(8);
    check_output("t2_write_count", wr_addr.size(), 2);
    check_output("t2_addr0", 32'(wr_addr[0]), 160);
    check_output("t2_data0", 32'(wr_data[0]), 32'h11);
    check_output("t2_addr1", 32'(wr_addr[1]), 161);
    check_output("t2_data1", 32'(wr_data[1]), 32'h22);
    check_output("t2_frame_done", fd_count, 1);
    check_output("t2_overflow_sticky", 32'(overflow), 1);

    // Address 200 is out of range: no write, overflow, no frame_done.
    clear_log();
    start_frame();
    check_output("t3_overflow_cleared", 32'(overflow), 0);
    send_word(8'd200, 8);
    send_word(8'h55, 8);
    end_frame(8);
    check_output("t3_write_count", wr_addr.size(), 0);
    check_output("t3_overflow", 32'(overflow), 1);
    check_output("t3_frame_done", fd_count, 0);

    // Reset while the 4th bit of the first data word is on the wire.
    clear_log();
    start_frame();
    send_word(8'd9, 8);
    send_word(8'hFF, 3);
    mosi = 1'b1;
    #40;
    sclk = 1'b1;
    #20;
    check_output("t5_busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check_output("t5_reset_mem_addr", 32'(mem_addr), 0);
    check_output("t5_reset_mem_data", 32'(mem_data), 0);
    check_output("t5_reset_overflow", 32'(overflow), 0);
    check_output("t5_reset_busy", 32'(busy), 0);
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    #50;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("t5_no_write", wr_addr.size(), 0);
    start_frame();
    send_word(8'd3, 8);
    send_word(8'h99, 8);
    end_frame(8);
    check_output("t5_write_count", wr_addr.size(), 1);
    check_output("t5_addr", 32'(wr_addr[0]), 3);
    check_output("t5_data", 32'(wr_data[0]), 32'h99);
    check_output("t5_frame_done", fd_count, 1);

    // Address 0, one data word, then a partial second word cut by cs_n.
    clear_log();
    start_frame();
    send_word(8'd0, 8);
    send_word(8'h7E, 8);
    send_word(8'hFF, 5);
    end_frame(8);
    check_output("t4_write_count", wr_addr.size(), 1);
    check_output("t4_addr", 32'(wr_addr[0]), 0);
    check_output("t4_data", 32'(wr_data[0]), 32'h7E);
    check_output("t4_frame_done", fd_count, 1);

    // Back-to-back frames separated by a 3-cycle cs_n gap.
    clear_log();
    start_frame();
    send_word(8'd10, 8);
    send_word(8'h01, 8);
    end_frame(3);
    start_frame();
    send_word(8'd20, 8);
    send_word(8'h02, 8);
    end_frame(8);
    check_output("t6_write_count", wr_addr.size(), 2);
    check_output("t6_addr0", 32'(wr_addr[0]), 10);
    check_output("t6_data0", 32'(wr_data[0]), 32'h01);
    check_output("t6_addr1", 32'(wr_addr[1]), 20);
    check_output("t6_data1", 32'(wr_data[1]), 32'h02);
    check_output("t6_frame_done", fd_count, 2);
    check_output("t6_strobe_width", long_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
